// File: rtl/memory_cycle_if.sv
// EX-to-MEM handshake and MEM-to-WB result bundle for the memory_cycle stage.
interface memory_cycle_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_RegWrite;
    logic        ex_MemToReg;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_Branch;
    logic [31:0] ex_ALUres;
    logic        ex_zero;
    logic [31:0] ex_Addresult;
    logic [31:0] ex_WriteData;
    logic [4:0]  ex_des_Register;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        wb_valid;
    logic        wb_RegWrite;
    logic        wb_MemToReg;
    logic [31:0] wb_ReadData;
    logic [31:0] wb_ALUres;
    logic [4:0]  wb_des_Register;
    logic        misaligned;

    modport master (
        output ex_valid, ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite, ex_Branch,
               ex_ALUres, ex_zero, ex_Addresult, ex_WriteData, ex_des_Register,
        input  ex_ready, PCSrc, BranchTarget, wb_valid, wb_RegWrite, wb_MemToReg,
               wb_ReadData, wb_ALUres, wb_des_Register, misaligned
    );

    modport slave (
        input  ex_valid, ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite, ex_Branch,
               ex_ALUres, ex_zero, ex_Addresult, ex_WriteData, ex_des_Register,
        output ex_ready, PCSrc, BranchTarget, wb_valid, wb_RegWrite, wb_MemToReg,
               wb_ReadData, wb_ALUres, wb_des_Register, misaligned
    );
endinterface

// File: rtl/memory_cycle.sv
// MIPS MEM stage: EX/MEM latch, branch resolve, word load/store on a local RAM with
// fixed wait states, and the MEM/WB register.
module memory_cycle #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned MEM_LATENCY = 2
) (
    input logic           clk,
    input logic           rst_n,
    memory_cycle_if.slave bus
);
    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             ready, accept, commit;

    logic        em_RegWrite, em_MemToReg, em_MemRead, em_MemWrite;
    logic [31:0] em_ALUres, em_WriteData;
    logic [4:0]  em_des_Register;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          aligned, is_load, is_store;

    assign idx      = em_ALUres[AW+1:2];
    assign aligned  = (em_ALUres[1:0] == 2'b00);
    // Both MemRead and MemWrite set is handled as a store.
    assign is_store = em_MemWrite;
    assign is_load  = em_MemRead & ~em_MemWrite;
    assign bus.ex_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        ready      = (state != WAIT);
        accept     = bus.ex_valid & ready;
        commit     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (bus.ex_MemRead | bus.ex_MemWrite) begin
                        next_state = WAIT;
                        next_cnt   = CNT_INIT;
                    end else begin
                        next_state = DONE;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = DONE;
                    commit     = 1'b1;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_RegWrite         <= 1'b0;
            em_MemToReg         <= 1'b0;
            em_MemRead          <= 1'b0;
            em_MemWrite         <= 1'b0;
            em_ALUres           <= '0;
            em_WriteData        <= '0;
            em_des_Register     <= '0;
            bus.PCSrc           <= 1'b0;
            bus.BranchTarget    <= '0;
            bus.wb_valid        <= 1'b0;
            bus.wb_RegWrite     <= 1'b0;
            bus.wb_MemToReg     <= 1'b0;
            bus.wb_ReadData     <= '0;
            bus.wb_ALUres       <= '0;
            bus.wb_des_Register <= '0;
            bus.misaligned      <= 1'b0;
        end else begin
            bus.PCSrc    <= 1'b0;
            bus.wb_valid <= 1'b0;
            if (accept) begin
                em_RegWrite      <= bus.ex_RegWrite;
                em_MemToReg      <= bus.ex_MemToReg;
                em_MemRead       <= bus.ex_MemRead;
                em_MemWrite      <= bus.ex_MemWrite;
                em_ALUres        <= bus.ex_ALUres;
                em_WriteData     <= bus.ex_WriteData;
                em_des_Register  <= bus.ex_des_Register;
                bus.BranchTarget <= bus.ex_Addresult;
                bus.PCSrc        <= bus.ex_Branch & bus.ex_zero;
                // Non-memory ops bypass the wait states and complete straight into MEM/WB.
                if (!(bus.ex_MemRead | bus.ex_MemWrite)) begin
                    bus.wb_valid        <= 1'b1;
                    bus.wb_RegWrite     <= bus.ex_RegWrite;
                    bus.wb_MemToReg     <= bus.ex_MemToReg;
                    bus.wb_ReadData     <= '0;
                    bus.wb_ALUres       <= bus.ex_ALUres;
                    bus.wb_des_Register <= bus.ex_des_Register;
                    bus.misaligned      <= 1'b0;
                end
            end
            if (commit) begin
                bus.wb_valid        <= 1'b1;
                bus.wb_RegWrite     <= em_RegWrite;
                bus.wb_MemToReg     <= em_MemToReg;
                bus.wb_ReadData     <= (is_load && aligned) ? mem[idx] : '0;
                bus.wb_ALUres       <= em_ALUres;
                bus.wb_des_Register <= em_des_Register;
                bus.misaligned      <= ~aligned;
            end
        end
    end

    // commit is only raised in WAIT, so an aborting reset never lets a store land.
    always_ff @(posedge clk) begin
        if (commit && is_store && aligned)
            mem[idx] <= em_WriteData;
    end
endmodule

// File: tb/tb_memory_cycle.sv
// Directed-vector bench for memory_cycle with DEPTH_WORDS=256, MEM_LATENCY=2.
module tb_memory_cycle;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    memory_cycle_if bus();

    memory_cycle #(.DEPTH_WORDS(256), .MEM_LATENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ex_valid = 0; bus.ex_RegWrite = 0; bus.ex_MemToReg = 0; bus.ex_MemRead = 0;
        bus.ex_MemWrite = 0; bus.ex_Branch = 0; bus.ex_zero = 0; bus.ex_ALUres = '0;
        bus.ex_Addresult = '0; bus.ex_WriteData = '0; bus.ex_des_Register = '0;
    endtask

    task automatic drive(input logic rw, m2r, mr, mw, br, z,
                         input logic [31:0] alu, wd, add, input logic [4:0] des);
        bus.ex_valid = 1; bus.ex_RegWrite = rw; bus.ex_MemToReg = m2r; bus.ex_MemRead = mr;
        bus.ex_MemWrite = mw; bus.ex_Branch = br; bus.ex_zero = z; bus.ex_ALUres = alu;
        bus.ex_WriteData = wd; bus.ex_Addresult = add; bus.ex_des_Register = des;
    endtask

    // Issue one op, then wait (bounded) for wb_valid; returns in the completion cycle.
    task automatic run_op(input string tag, input logic rw, m2r, mr, mw, br, z,
                          input logic [31:0] alu, wd, add, input logic [4:0] des,
                          input int exp_lat);
        int lat;
        int stall;
        @(negedge clk);
        drive(rw, m2r, mr, mw, br, z, alu, wd, add, des);
        check({tag, "_rdy"}, bus.ex_ready, 1);
        lat = 0;
        stall = 0;
        do begin
            @(negedge clk);
            idle_inputs();
            lat++;
            if (!bus.ex_ready) stall++;
        end while (!bus.wb_valid && lat < 10);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_stall"}, stall, exp_lat - 1);
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_pcsrc", bus.PCSrc, 0);
        check("rst_btarget", bus.BranchTarget, 0);
        check("rst_wb_alu", bus.wb_ALUres, 0);
        check("rst_misaligned", bus.misaligned, 0);
        check("rst_ready", bus.ex_ready, 1);
        rst_n = 1;

        // ALU op: one-cycle latency, then wb_* hold with wb_valid low.
        run_op("alu", 1, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 5'd5, 1);
        check("alu_wb_alu", bus.wb_ALUres, 32'h1234);
        check("alu_wb_des", bus.wb_des_Register, 5);
        check("alu_wb_rw", bus.wb_RegWrite, 1);
        check("alu_wb_rd", bus.wb_ReadData, 0);
        @(negedge clk);
        check("alu_wb_drop", bus.wb_valid, 0);
        check("alu_wb_hold", bus.wb_ALUres, 32'h1234);

        // Back-to-back ALU ops complete every cycle.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 32'h1, 0, 0, 5'd1);
        @(negedge clk);
        check("b2b_v1", bus.wb_valid, 1);
        check("b2b_a1", bus.wb_ALUres, 32'h1);
        drive(1, 0, 0, 0, 0, 0, 32'h2, 0, 0, 5'd2);
        @(negedge clk);
        idle_inputs();
        check("b2b_v2", bus.wb_valid, 1);
        check("b2b_a2", bus.wb_ALUres, 32'h2);

        // Store then load same word.
        run_op("st40", 0, 0, 0, 1, 0, 0, 32'h40, 32'hDEADBEEF, 0, 0, 3);
        check("st40_rd", bus.wb_ReadData, 0);
        check("st40_mis", bus.misaligned, 0);
        run_op("ld40", 1, 1, 1, 0, 0, 0, 32'h40, 0, 0, 5'd7, 3);
        check("ld40_rd", bus.wb_ReadData, 32'hDEADBEEF);
        check("ld40_m2r", bus.wb_MemToReg, 1);
        check("ld40_des", bus.wb_des_Register, 7);

        // Branch resolve.
        run_op("br1", 0, 0, 0, 0, 1, 1, 0, 0, 32'h80, 0, 1);
        check("br1_pcsrc", bus.PCSrc, 1);
        check("br1_target", bus.BranchTarget, 32'h80);
        @(negedge clk);
        check("br1_pcsrc_drop", bus.PCSrc, 0);
        run_op("br0", 0, 0, 0, 0, 1, 0, 0, 0, 32'h90, 0, 1);
        check("br0_pcsrc", bus.PCSrc, 0);
        check("br0_target", bus.BranchTarget, 32'h90);

        // Misaligned accesses.
        run_op("ld42", 1, 1, 1, 0, 0, 0, 32'h42, 0, 0, 5'd3, 3);
        check("ld42_mis", bus.misaligned, 1);
        check("ld42_rd", bus.wb_ReadData, 0);
        run_op("st41", 0, 0, 0, 1, 0, 0, 32'h41, 32'h11111111, 0, 0, 3);
        check("st41_mis", bus.misaligned, 1);
        run_op("ld40b", 1, 1, 1, 0, 0, 0, 32'h40, 0, 0, 5'd3, 3);
        check("ld40b_rd", bus.wb_ReadData, 32'hDEADBEEF);
        check("ld40b_mis", bus.misaligned, 0);

        // Aliasing wrap-around.
        run_op("st0", 0, 0, 0, 1, 0, 0, 32'h0, 32'hCAFEF00D, 0, 0, 3);
        run_op("ld400", 1, 1, 1, 0, 0, 0, 32'h400, 0, 0, 5'd9, 3);
        check("ld400_rd", bus.wb_ReadData, 32'hCAFEF00D);
        check("ld400_alu", bus.wb_ALUres, 32'h400);

        // MemRead & MemWrite together behave as a store.
        run_op("rw44", 0, 0, 1, 1, 0, 0, 32'h44, 32'h00000055, 0, 0, 3);
        check("rw44_rd", bus.wb_ReadData, 0);
        run_op("ld44", 1, 1, 1, 0, 0, 0, 32'h44, 0, 0, 5'd4, 3);
        check("ld44_rd", bus.wb_ReadData, 32'h55);

        // Reset mid-store aborts the write.
        run_op("st10", 0, 0, 0, 1, 0, 0, 32'h10, 32'hA5A5A5A5, 0, 0, 3);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0, 32'h10, 32'h12345678, 0, 0);
        @(negedge clk);
        idle_inputs();
        check("abort_in_wait", bus.ex_ready, 0);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_wb", bus.wb_valid, 0);
        end
        check("abort_ready", bus.ex_ready, 1);
        run_op("ld10", 1, 1, 1, 0, 0, 0, 32'h10, 0, 0, 5'd2, 3);
        check("ld10_rd", bus.wb_ReadData, 32'hA5A5A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
